// File: rtl/mem_arbiter_if.sv
// Consumer-side and memory-side bundles of mem_arbiter as flat packed vectors.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mem_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]            mem_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]            mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS valid/ready requesters.
// Define MEM_ARBITER_ROUND_ROBIN_EN for per-channel round-robin search; default is fixed priority.
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CIDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } chan_state_t;

    logic [ADDR_BITS-1:0]     cons_raddr_s [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     cons_waddr_s [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     cons_wdata_s [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     mem_rdata_s  [NUM_CHANNELS];

    chan_state_t              state_r      [NUM_CHANNELS];
    logic [CIDX_W-1:0]        owner_r      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  op_write_r;
    logic [NUM_CHANNELS-1:0]  mem_rvalid_r;
    logic [NUM_CHANNELS-1:0]  mem_wvalid_r;
    logic [ADDR_BITS-1:0]     mem_raddr_r  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_waddr_r  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_wdata_r  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] cons_rready_r;
    logic [NUM_CONSUMERS-1:0] cons_wready_r;
    logic [DATA_BITS-1:0]     cons_rdata_r [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0] write_req_s;
    logic [NUM_CONSUMERS-1:0] pending_s;
    logic [NUM_CONSUMERS-1:0] claimed_s;
    logic [NUM_CONSUMERS-1:0] taken_s;
    logic [NUM_CHANNELS-1:0]  grant_s;
    logic [NUM_CHANNELS-1:0]  grant_write_s;
    logic [CIDX_W-1:0]        grant_idx_s  [NUM_CHANNELS];
    logic [CIDX_W-1:0]        cand_s;
    logic                     hit_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [CIDX_W-1:0]        ptr_r        [NUM_CHANNELS];
    logic [CIDX_W:0]          sum_s;

    function automatic logic [CIDX_W-1:0] next_index(input logic [CIDX_W-1:0] idx);
        logic [CIDX_W:0] inc;
        inc = {1'b0, idx} + {{CIDX_W{1'b0}}, 1'b1};
        return (inc >= (CIDX_W+1)'(NUM_CONSUMERS)) ? {CIDX_W{1'b0}} : inc[CIDX_W-1:0];
    endfunction
`endif

    for (genvar gc = 0; gc < NUM_CONSUMERS; gc++) begin : g_cons
        assign cons_raddr_s[gc] = bus.consumer_read_address[gc*ADDR_BITS +: ADDR_BITS];
        assign cons_waddr_s[gc] = bus.consumer_write_address[gc*ADDR_BITS +: ADDR_BITS];
        assign cons_wdata_s[gc] = bus.consumer_write_data[gc*DATA_BITS +: DATA_BITS];
        assign bus.consumer_read_data[gc*DATA_BITS +: DATA_BITS] = cons_rdata_r[gc];
    end

    for (genvar gh = 0; gh < NUM_CHANNELS; gh++) begin : g_chan
        assign mem_rdata_s[gh] = bus.mem_read_data[gh*DATA_BITS +: DATA_BITS];
        assign bus.mem_read_address[gh*ADDR_BITS +: ADDR_BITS] = mem_raddr_r[gh];
        assign bus.mem_write_address[gh*ADDR_BITS +: ADDR_BITS] =
            (WRITE_ENABLE != 0) ? mem_waddr_r[gh] : {ADDR_BITS{1'b0}};
        assign bus.mem_write_data[gh*DATA_BITS +: DATA_BITS] =
            (WRITE_ENABLE != 0) ? mem_wdata_r[gh] : {DATA_BITS{1'b0}};
    end

    assign write_req_s              = (WRITE_ENABLE != 0) ? bus.consumer_write_valid : {NUM_CONSUMERS{1'b0}};
    assign pending_s                = bus.consumer_read_valid | write_req_s;
    assign bus.mem_read_valid       = mem_rvalid_r;
    assign bus.mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wvalid_r : {NUM_CHANNELS{1'b0}};
    assign bus.consumer_read_ready  = cons_rready_r;
    assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ? cons_wready_r : {NUM_CONSUMERS{1'b0}};

    // Consumers currently owned by a busy channel.
    always_comb begin
        claimed_s = {NUM_CONSUMERS{1'b0}};
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            claimed_s[owner_r[ch]] = claimed_s[owner_r[ch]] | (state_r[ch] != IDLE);
        end
    end

    // Grant search: channels resolve in ascending order, each consumer taken at most once.
    always_comb begin
        taken_s       = {NUM_CONSUMERS{1'b0}};
        grant_s       = {NUM_CHANNELS{1'b0}};
        grant_write_s = {NUM_CHANNELS{1'b0}};
        cand_s        = {CIDX_W{1'b0}};
        hit_s         = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        sum_s         = {(CIDX_W+1){1'b0}};
`endif
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_idx_s[ch] = {CIDX_W{1'b0}};
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                sum_s  = {1'b0, ptr_r[ch]} + (CIDX_W+1)'(k);
                sum_s  = (sum_s >= (CIDX_W+1)'(NUM_CONSUMERS)) ? sum_s - (CIDX_W+1)'(NUM_CONSUMERS) : sum_s;
                cand_s = sum_s[CIDX_W-1:0];
`else
                cand_s = CIDX_W'(k);
`endif
                hit_s = (state_r[ch] == IDLE) && !grant_s[ch] && pending_s[cand_s]
                        && !claimed_s[cand_s] && !taken_s[cand_s];
                grant_idx_s[ch]   = hit_s ? cand_s : grant_idx_s[ch];
                grant_write_s[ch] = hit_s ? ~bus.consumer_read_valid[cand_s] : grant_write_s[ch];
                taken_s[cand_s]   = taken_s[cand_s] | hit_s;
                grant_s[ch]       = grant_s[ch] | hit_s;
            end
        end
    end

    // Per-channel state machines with registered memory and consumer outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_write_r    <= {NUM_CHANNELS{1'b0}};
            mem_rvalid_r  <= {NUM_CHANNELS{1'b0}};
            mem_wvalid_r  <= {NUM_CHANNELS{1'b0}};
            cons_rready_r <= {NUM_CONSUMERS{1'b0}};
            cons_wready_r <= {NUM_CONSUMERS{1'b0}};
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_r[ch]     <= IDLE;
                owner_r[ch]     <= {CIDX_W{1'b0}};
                mem_raddr_r[ch] <= {ADDR_BITS{1'b0}};
                mem_waddr_r[ch] <= {ADDR_BITS{1'b0}};
                mem_wdata_r[ch] <= {DATA_BITS{1'b0}};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                ptr_r[ch]       <= {CIDX_W{1'b0}};
`endif
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                cons_rdata_r[c] <= {DATA_BITS{1'b0}};
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_r[ch])
                    IDLE: begin
                        if (grant_s[ch]) begin
                            owner_r[ch]    <= grant_idx_s[ch];
                            op_write_r[ch] <= grant_write_s[ch];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                            ptr_r[ch]      <= next_index(grant_idx_s[ch]);
`endif
                            if (grant_write_s[ch]) begin
                                state_r[ch]      <= WRITE_WAIT;
                                mem_wvalid_r[ch] <= 1'b1;
                                mem_waddr_r[ch]  <= cons_waddr_s[grant_idx_s[ch]];
                                mem_wdata_r[ch]  <= cons_wdata_s[grant_idx_s[ch]];
                            end else begin
                                state_r[ch]      <= READ_WAIT;
                                mem_rvalid_r[ch] <= 1'b1;
                                mem_raddr_r[ch]  <= cons_raddr_s[grant_idx_s[ch]];
                            end
                        end else begin
                            state_r[ch] <= IDLE;
                        end
                    end
                    READ_WAIT: begin
                        if (bus.mem_read_ready[ch]) begin
                            mem_rvalid_r[ch]            <= 1'b0;
                            cons_rready_r[owner_r[ch]]  <= 1'b1;
                            cons_rdata_r[owner_r[ch]]   <= mem_rdata_s[ch];
                            state_r[ch]                 <= RELAY;
                        end else begin
                            state_r[ch] <= READ_WAIT;
                        end
                    end
                    WRITE_WAIT: begin
                        if (bus.mem_write_ready[ch]) begin
                            mem_wvalid_r[ch]           <= 1'b0;
                            cons_wready_r[owner_r[ch]] <= 1'b1;
                            state_r[ch]                <= RELAY;
                        end else begin
                            state_r[ch] <= WRITE_WAIT;
                        end
                    end
                    RELAY: begin
                        // Hold ready until the consumer withdraws the request that was served.
                        if (op_write_r[ch] ? ~write_req_s[owner_r[ch]] : ~bus.consumer_read_valid[owner_r[ch]]) begin
                            cons_rready_r[owner_r[ch]] <= 1'b0;
                            cons_wready_r[owner_r[ch]] <= 1'b0;
                            cons_rdata_r[owner_r[ch]]  <= {DATA_BITS{1'b0}};
                            state_r[ch]                <= IDLE;
                        end else begin
                            state_r[ch] <= RELAY;
                        end
                    end
                    default: begin
                        state_r[ch] <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
